// File: rtl/sdram_frame_reader.sv
// Streams one frame of RGB565 pixels from SDRAM into the display FIFO, one burst at a time.
// Optional macro FRAME_CNT_EN adds a 16-bit completed-frame counter output (frame_cnt).
module sdram_frame_reader #(
    parameter int FRAME_W    = 320,
    parameter int FRAME_H    = 240,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 4096,
    parameter int BASE_ADDR  = 0
) (
    input  logic        clk_sdram,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [11:0] fifo_wrusedw,
    output logic        rd_req,
    output logic [23:0] rd_addr,
    input  logic        rd_ack,
    input  logic        rd_valid,
    input  logic [15:0] rd_data,
    output logic [15:0] sdram_data,
    output logic        wr_fifo,
    output logic        frame_done,
`ifdef FRAME_CNT_EN
    output logic [15:0] frame_cnt,
`endif
    output logic        busy
);

    localparam int                TOTAL_PIX      = FRAME_W * FRAME_H;
    localparam int                BEAT_W         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [16:0]       LAST_BURST_PIX = 17'(TOTAL_PIX - BURST_LEN);
    localparam logic [16:0]       BURST_STEP     = 17'(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT      = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE       = BEAT_W'(1);
    localparam logic [23:0]       BASE_WORD      = 24'(BASE_ADDR);
    // Two bursts of headroom so an in-flight burst can never overrun the FIFO.
    localparam logic [31:0]       SPACE_LIMIT    = 32'(FIFO_DEPTH - 2 * BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_SPACE = 2'd1,
        S_REQ        = 2'd2,
        S_BURST      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [16:0]       pix_q, pix_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              rd_req_q, rd_req_d;
    logic [23:0]       rd_addr_q, rd_addr_d;
    logic [15:0]       sdram_data_q, sdram_data_d;
    logic              wr_fifo_q, wr_fifo_d;
    logic              frame_done_q, frame_done_d;
    logic              busy_q, busy_d;
    logic              space_ok;

    assign space_ok = ({20'd0, fifo_wrusedw} <= SPACE_LIMIT);

    // Next-state and registered-output computation for the burst sequencer.
    always_comb begin
        state_d      = state_q;
        pix_d        = pix_q;
        beat_d       = beat_q;
        rd_req_d     = rd_req_q;
        rd_addr_d    = rd_addr_q;
        sdram_data_d = sdram_data_q;
        wr_fifo_d    = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_WAIT_SPACE;
                    pix_d   = 17'd0;
                    beat_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_SPACE: begin
                if (space_ok) begin
                    state_d   = S_REQ;
                    rd_req_d  = 1'b1;
                    rd_addr_d = BASE_WORD + {7'd0, pix_q};
                end else begin
                    state_d = S_WAIT_SPACE;
                end
            end
            S_REQ: begin
                if (rd_ack) begin
                    state_d  = S_BURST;
                    rd_req_d = 1'b0;
                    beat_d   = '0;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_BURST: begin
                if (rd_valid) begin
                    sdram_data_d = rd_data;
                    wr_fifo_d    = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        // Comparing with >= keeps the index from ever running past the frame.
                        if (pix_q >= LAST_BURST_PIX) begin
                            pix_d        = 17'd0;
                            frame_done_d = 1'b1;
                            state_d      = enable ? S_WAIT_SPACE : S_IDLE;
                        end else begin
                            pix_d   = pix_q + BURST_STEP;
                            state_d = S_WAIT_SPACE;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_ONE;
                    end
                end else begin
                    state_d = S_BURST;
                end
            end
            default: begin
                state_d  = S_IDLE;
                rd_req_d = 1'b0;
                pix_d    = 17'd0;
                beat_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_sdram) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pix_q        <= 17'd0;
            beat_q       <= '0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= 24'd0;
            sdram_data_q <= 16'd0;
            wr_fifo_q    <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            beat_q       <= beat_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            sdram_data_q <= sdram_data_d;
            wr_fifo_q    <= wr_fifo_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign rd_req     = rd_req_q;
    assign rd_addr    = rd_addr_q;
    assign sdram_data = sdram_data_q;
    assign wr_fifo    = wr_fifo_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

`ifdef FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Counter advances in step with the frame_done pulse and wraps naturally.
    always_comb begin
        if (frame_done_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk_sdram) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Randomized self-checking bench for sdram_frame_reader; the bench plays the SDRAM controller
// and predicts addresses, pixel data and frame boundaries from a simple pixel-index model.
module tb_sdram_frame_reader;

    localparam int FW    = 32;
    localparam int FH    = 4;
    localparam int BL    = 8;
    localparam int DEPTH = 4096;
    localparam int BASE  = 0;
    localparam int TOTAL = FW * FH;
    localparam int NBURST = TOTAL / BL;

    logic        clk_sdram = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [11:0] fifo_wrusedw;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [15:0] sdram_data;
    logic        wr_fifo;
    logic        frame_done;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int exp_pix  = 0;

    always #5 clk_sdram = ~clk_sdram;

    sdram_frame_reader #(
        .FRAME_W   (FW),
        .FRAME_H   (FH),
        .BURST_LEN (BL),
        .FIFO_DEPTH(DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_sdram   (clk_sdram),
        .rst_n       (rst_n),
        .enable      (enable),
        .fifo_wrusedw(fifo_wrusedw),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .sdram_data  (sdram_data),
        .wr_fifo     (wr_fifo),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sdram);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd_req"}, rd_req, 32'd0);
        check_eq({tag, "_rd_addr"}, rd_addr, 32'd0);
        check_eq({tag, "_wr_fifo"}, wr_fifo, 32'd0);
        check_eq({tag, "_frame_done"}, frame_done, 32'd0);
        check_eq({tag, "_busy"}, busy, 32'd0);
        check_eq({tag, "_sdram_data"}, sdram_data, 32'd0);
    endtask

    // One request/burst exchange; abort_at >= 0 pulls rst_n low together with that beat.
    task automatic do_burst(input int ack_dly, input int gap_max, input int abort_at, input bit fixed_data);
        int          waited;
        int          gap;
        logic [23:0] exp_addr;
        logic [15:0] beat;
        bit          last_frame;
        waited   = 0;
        exp_addr = 24'(BASE + exp_pix);
        while (rd_req !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        check_eq("rd_req_rise", rd_req, 32'd1);
        check_eq("rd_addr", rd_addr, exp_addr);
        check_eq("busy_req", busy, 32'd1);
        for (int k = 0; k < ack_dly; k++) begin
            tick();
            check_eq("rd_req_hold", rd_req, 32'd1);
            check_eq("rd_addr_hold", rd_addr, exp_addr);
        end
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        check_eq("rd_req_drop", rd_req, 32'd0);
        last_frame = (exp_pix + BL == TOTAL);
        for (int i = 0; i < BL; i++) begin
            gap = $urandom_range(0, gap_max);
            for (int g = 0; g < gap; g++) begin
                tick();
                check_eq("wr_fifo_gap", wr_fifo, 32'd0);
                check_eq("frame_done_gap", frame_done, 32'd0);
            end
            beat     = fixed_data ? 16'(16'h1111 * (i + 1)) : 16'($urandom);
            rd_valid = 1'b1;
            rd_data  = beat;
            if (i == abort_at) rst_n = 1'b0;
            tick();
            rd_valid = 1'b0;
            if (i == abort_at) begin
                check_all_zero("abort");
                rst_n   = 1'b1;
                exp_pix = 0;
                return;
            end
            check_eq("wr_fifo", wr_fifo, 32'd1);
            check_eq("sdram_data", sdram_data, beat);
            check_eq("frame_done", frame_done, (last_frame && i == BL - 1) ? 32'd1 : 32'd0);
            if (i == BL - 1) check_eq("busy_end", busy, (last_frame && !enable) ? 32'd0 : 32'd1);
        end
        exp_pix = last_frame ? 0 : exp_pix + BL;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        rst_n        = 1'b0;
        enable       = 1'b0;
        fifo_wrusedw = 12'd0;
        rd_ack       = 1'b0;
        rd_valid     = 1'b0;
        rd_data      = 16'd0;
        repeat (3) tick();
        check_all_zero("reset");

        // Idle with enable low: stray beats must not reach the FIFO.
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_valid = 1'b1;
            rd_data  = 16'($urandom);
            tick();
            check_eq("idle_wr_fifo", wr_fifo, 32'd0);
            check_eq("idle_busy", busy, 32'd0);
            check_eq("idle_rd_req", rd_req, 32'd0);
        end
        rd_valid = 1'b0;

        enable = 1'b1;
        do_burst(2, 0, -1, 1'b1);
        do_burst(0, 0, -1, 1'b0);

        // FIFO too full: no request, and stray beats ignored while waiting.
        fifo_wrusedw = 12'd4081;
        for (int i = 0; i < 8; i++) begin
            rd_valid = i[0];
            rd_data  = 16'($urandom);
            tick();
            check_eq("full_rd_req", rd_req, 32'd0);
            check_eq("full_wr_fifo", wr_fifo, 32'd0);
        end
        rd_valid     = 1'b0;
        fifo_wrusedw = 12'd4080;
        waited       = 0;
        while (rd_req !== 1'b1 && waited < 2) begin
            tick();
            waited++;
        end
        check_eq("space_release", rd_req, 32'd1);
        do_burst(1, 1, -1, 1'b0);

        // Remainder of frame one, then all of frame two with enable dropped mid-frame.
        for (int b = 3; b < NBURST; b++) begin
            fifo_wrusedw = 12'($urandom_range(0, 4080));
            do_burst($urandom_range(0, 3), 2, -1, 1'b0);
        end
        for (int b = 0; b < NBURST; b++) begin
            if (b == 5) enable = 1'b0;
            fifo_wrusedw = 12'($urandom_range(0, 4080));
            do_burst($urandom_range(0, 3), 2, -1, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("stopped_rd_req", rd_req, 32'd0);
            check_eq("stopped_busy", busy, 32'd0);
        end

        // Restart, then reset at beat 4 of the second burst.
        enable       = 1'b1;
        fifo_wrusedw = 12'd0;
        do_burst(0, 1, -1, 1'b0);
        do_burst(1, 1, 4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            rd_valid = 1'b1;
            rd_data  = 16'($urandom);
            tick();
            check_eq("post_reset_wr_fifo", wr_fifo, 32'd0);
        end
        rd_valid = 1'b0;
        do_burst(1, 2, -1, 1'b0);
        do_burst(0, 2, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sdram_frame_reader.md
SDRAM_FRAME_READER -- requirements
Module: sdram_frame_reader

Interface
REQ-001 SHALL have parameter FRAME_W, default 320, pixels per line.
REQ-002 SHALL have parameter FRAME_H, default 240, lines per frame.
REQ-003 SHALL have parameter BURST_LEN, default 8, pixels per SDRAM read burst; FRAME_W*FRAME_H divisible by BURST_LEN.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4096, display FIFO depth in words.
REQ-005 SHALL have parameter BASE_ADDR, default 0, SDRAM word address of pixel (0,0).
REQ-006 SHALL have port clk_sdram, in, 1, the single clock.
REQ-007 SHALL have port rst_n, in, 1, reset, synchronous active-low.
REQ-008 SHALL have port enable, in, 1, run frames while high.
REQ-009 SHALL have port fifo_wrusedw, in, 12, display FIFO write-side fill level.
REQ-010 SHALL have port rd_req, out, 1, SDRAM burst read request.
REQ-011 SHALL have port rd_addr, out, 24, burst start word address.
REQ-012 SHALL have port rd_ack, in, 1, controller accepted request.
REQ-013 SHALL have port rd_valid, in, 1, read beat valid.
REQ-014 SHALL have port rd_data, in, 16, RGB565 read beat.
REQ-015 SHALL have port sdram_data, out, 16, pixel to display FIFO.
REQ-016 SHALL have port wr_fifo, out, 1, display FIFO write strobe.
REQ-017 SHALL have port frame_done, out, 1, one-cycle pulse on last pixel of frame.
REQ-018 SHALL have port busy, out, 1, high in any state except IDLE.

Function
REQ-019 SHALL implement states IDLE, WAIT_SPACE, REQ, BURST.
REQ-020 IDLE SHALL go to WAIT_SPACE when enable=1, with pixel index cleared to 0.
REQ-021 WAIT_SPACE SHALL go to REQ when fifo_wrusedw <= FIFO_DEPTH-2*BURST_LEN (4080 at defaults), else hold.
REQ-022 REQ SHALL drive rd_req=1 and rd_addr=BASE_ADDR+pixel index, both stable until rd_ack is sampled high.
REQ-023 On rd_ack, rd_req SHALL drop the next cycle and the FSM SHALL enter BURST.
REQ-024 Only one burst SHALL be outstanding at any time.
REQ-025 In BURST, each rd_valid beat SHALL register rd_data into sdram_data and pulse wr_fifo exactly one cycle later.
REQ-026 rd_valid outside BURST SHALL be ignored.
REQ-027 After BURST_LEN beats, pixel index SHALL advance by BURST_LEN.
REQ-028 If more pixels remain in the frame, the FSM SHALL return to WAIT_SPACE.
REQ-029 On the last burst, frame_done SHALL pulse coincident with the final wr_fifo pulse and pixel index SHALL wrap to 0.
REQ-030 After the last burst, the FSM SHALL go to WAIT_SPACE if enable=1, else to IDLE.
REQ-031 Deasserting enable mid-frame SHALL not abort: the current frame SHALL complete.
REQ-032 Pixel index SHALL be 17 bits, with no overflow beyond FRAME_W*FRAME_H-1.
REQ-033 Address arithmetic SHALL be modulo 2^24.

Reset
REQ-034 rst_n=0 at a clk_sdram edge SHALL force IDLE, pixel index 0, beat count 0, and rd_req, wr_fifo, frame_done, busy, sdram_data all 0.
REQ-035 Reset mid-burst SHALL discard the remaining beats; the next frame SHALL restart at BASE_ADDR.

Configuration
REQ-036 With FRAME_CNT_EN defined, the block SHALL add output frame_cnt, 16 bits, reset to 0, incremented on each frame_done pulse and wrapping 0xFFFF->0x0000.
REQ-037 Without FRAME_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-038 Reset then enable=1, fifo_wrusedw=0, rd_ack after 2 cycles -> rd_req=1 with rd_addr=0x000000; after 8 beats, next rd_addr=0x000008.
REQ-039 Beats 0x1111..0x8888 -> sdram_data carries the same 8 words in order, each wr_fifo one cycle after its rd_valid.
REQ-040 fifo_wrusedw=4081 -> no rd_req; drop to 4080 -> rd_req asserts within 2 cycles.
REQ-041 Full frame (9600 bursts) -> last rd_addr=0x012BF8, frame_done single pulse, next rd_addr=0x000000.
REQ-042 enable drops at burst 100 -> frame completes, FSM reaches IDLE, busy=0, no further rd_req.
REQ-043 rst_n=0 at beat 4 of a burst -> all outputs 0 next cycle; after re-enable, rd_addr=0x000000.
